// File: rtl/recip_sched.sv
// recip_sched: round-robin scheduler that shares one iterative 9-bit reciprocal divider,
// with a one-entry last-result cache and a saturating divide-by-zero shortcut.
module recip_sched #(
  parameter int N_REQ       = 4,
  parameter int DIV_LATENCY = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [9*N_REQ-1:0] req_denom,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [15:0]        rsp_recip,
  input  logic               flush,
  output logic               div_start,
  output logic [8:0]         div_denom,
  input  logic [15:0]        div_recip,
  output logic               busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(DIV_LATENCY + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, CAPTURE = 2'd3;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  logic [1:0] state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, cur_id_q, cur_id_d, gnt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0] cur_denom_q, cur_denom_d, cache_denom_q, cache_denom_d, gnt_denom;
  logic [15:0] cache_recip_q, cache_recip_d, rsp_recip_q, rsp_recip_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic cache_v_q, cache_v_d, grant, hit, zero;
  // Scan downwards so the nearest valid index at or after rr_q is the last to win.
  always_comb begin
    gnt = rr_q;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_q) + k) % N_REQ]) gnt = IW'((int'(rr_q) + k) % N_REQ);
  end
  assign grant     = rst_n && state_q == IDLE && |req_valid;
  assign gnt_denom = req_denom[9*int'(gnt) +: 9];
  assign zero      = gnt_denom == 9'd0;
  assign hit       = cache_v_q && !flush && gnt_denom == cache_denom_q;
  assign req_ready = grant ? ONE << gnt : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_recip = rsp_recip_q;
  assign div_start = state_q == ISSUE;
  assign div_denom = cur_denom_q;
  assign busy      = state_q != IDLE;
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    cur_id_d      = cur_id_q;
    cur_denom_d   = cur_denom_q;
    cnt_d         = cnt_q;
    cache_v_d     = cache_v_q && !flush;
    cache_denom_d = cache_denom_q;
    cache_recip_d = cache_recip_q;
    rsp_recip_d   = rsp_recip_q;
    rsp_valid_d   = '0;
    if (grant) begin
      rr_d        = int'(gnt) == N_REQ - 1 ? '0 : gnt + IW'(1);
      cur_id_d    = gnt;
      cur_denom_d = gnt_denom;
      rsp_valid_d = zero || hit ? req_ready : '0;
      rsp_recip_d = zero ? 16'hFFFF : hit ? cache_recip_q : rsp_recip_q;
      state_d     = zero || hit ? IDLE : ISSUE;
    end
    if (state_q == ISSUE) begin
      cnt_d   = CW'(DIV_LATENCY - 1);
      state_d = WAIT;
    end
    if (state_q == WAIT) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q <= CW'(1) ? CAPTURE : WAIT;
    end
    // A fill in CAPTURE overrides a concurrent flush.
    if (state_q == CAPTURE) begin
      rsp_recip_d   = div_recip;
      cache_recip_d = div_recip;
      cache_denom_d = cur_denom_q;
      cache_v_d     = 1'b1;
      rsp_valid_d   = ONE << cur_id_q;
      state_d       = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      cur_id_q      <= '0;
      cur_denom_q   <= '0;
      cnt_q         <= '0;
      cache_v_q     <= 1'b0;
      cache_denom_q <= '0;
      cache_recip_q <= '0;
      rsp_recip_q   <= '0;
      rsp_valid_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      cur_id_q      <= cur_id_d;
      cur_denom_q   <= cur_denom_d;
      cnt_q         <= cnt_d;
      cache_v_q     <= cache_v_d;
      cache_denom_q <= cache_denom_d;
      cache_recip_q <= cache_recip_d;
      rsp_recip_q   <= rsp_recip_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end
endmodule

// File: tb/tb_recip_sched.sv
// tb_recip_sched: directed and random requests against a timestamp-based model of the scheduler.
module tb_recip_sched;
  localparam int N = 4, DL = 16;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, nv, rerq = '0;
  logic [9*N-1:0] req_denom = '0, nd;
  logic [15:0] rsp_recip, div_recip = '0;
  logic [8:0] div_denom, ds_d = '0;
  logic div_start, busy;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_free, m_rr, issue_at, cap_at, exp_at, exp_id, ds_at = -1, flush_at = -1;
  int last_g = 0, last_rsp = 0;
  logic [15:0] exp_val, c_r;
  logic [8:0] c_d, m_dd;
  logic c_v, rnd = 1'b0;
  int gq[$];
  int exp_ord[5] = '{0, 1, 2, 3, 0};

  recip_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_denom(req_denom),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_recip(rsp_recip), .flush(flush),
    .div_start(div_start), .div_denom(div_denom), .div_recip(div_recip), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] recip(input logic [8:0] d);
    logic [31:0] q;
    q = 32'd65536 / {23'd0, d};
    return q[15:0];
  endfunction

  function automatic logic [8:0] pick();
    case ($urandom % 6)
      0: return 9'd0;
      1: return 9'd3;
      2: return 9'd256;
      3: return 9'd5;
      4: return 9'd7;
      default: return 9'($urandom);
    endcase
  endfunction

  task automatic model_clear();
    m_free = 0; m_rr = 0; issue_at = -100; cap_at = -100; exp_at = -100; exp_id = 0; c_v = 1'b0;
  endtask

  task automatic eval();
    logic [N-1:0] er;
    logic [8:0] d;
    int g;
    er = '0;
    g = -1;
    if (rst_n && cyc >= m_free && |req_valid) begin
      for (int k = 0; k < N; k++) if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      er[g] = 1'b1;
    end
    check("req_ready", req_ready, er);
    check("rsp_valid", rsp_valid, cyc == exp_at ? (1 << exp_id) : 0);
    check("div_start", div_start, cyc == issue_at);
    check("busy", busy, cyc < m_free);
    if (cyc == exp_at) check("rsp_recip", rsp_recip, exp_val);
    if (cyc >= issue_at && cyc <= cap_at) check("div_denom", div_denom, m_dd);
    if (div_start) begin ds_at = cyc; ds_d = div_denom; end
    if (rsp_valid != 0) last_rsp = cyc;
    if (req_ready != 0) begin
      last_g = cyc;
      for (int i = 0; i < N; i++) if (req_ready[i]) gq.push_back(i);
    end
    if (g >= 0) begin
      d = req_denom[9*g +: 9];
      m_rr = (g + 1) % N;
      exp_id = g;
      if (d == 0) begin exp_at = cyc + 1; exp_val = 16'hFFFF; m_free = cyc + 1; end
      else if (c_v && !flush && d == c_d) begin exp_at = cyc + 1; exp_val = c_r; m_free = cyc + 1; end
      else begin
        issue_at = cyc + 1; cap_at = cyc + 1 + DL; exp_at = cyc + 2 + DL;
        exp_val = recip(d); m_free = exp_at; m_dd = d;
      end
    end
    if (cyc == cap_at) begin c_v = 1'b1; c_d = m_dd; c_r = recip(m_dd); end
    else if (flush) c_v = 1'b0;
    nv = req_valid;
    nd = req_denom;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        if (rnd && $urandom % 2 == 0) nd[9*i +: 9] = pick();
        else if (!rnd && rerq[i]) begin nd[9*i +: 9] = nd[9*i +: 9] + 9'd1; rerq[i] = 1'b0; end
        else nv[i] = 1'b0;
      end else if (rnd && !nv[i] && $urandom % 4 == 0) begin
        nv[i] = 1'b1;
        nd[9*i +: 9] = pick();
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      eval();
      @(posedge clk);
      #1;
      cyc++;
      req_valid = nv;
      req_denom = nd;
      flush = cyc == flush_at || (rnd && $urandom % 16 == 0);
      div_recip = ds_at >= 0 && cyc - ds_at >= DL ? recip(ds_d) : 16'($urandom);
    end
  endtask

  task automatic req(input int i, input logic [8:0] d);
    req_valid[i] = 1'b1;
    req_denom[9*i +: 9] = d;
  endtask

  initial begin
    model_clear();
    run(3);
    check("rst_recip", rsp_recip, 16'h0);
    check("rst_denom", div_denom, 9'h0);
    rst_n = 1'b1;
    run(2);
    req(0, 9'd256); run(20);
    check("lat_miss", last_rsp - last_g, 18);
    req(1, 9'd3); run(20);
    req(1, 9'd3); run(3);
    check("lat_hit", last_rsp - last_g, 1);
    flush = 1'b1; run(1);
    req(1, 9'd3); run(20);
    check("lat_flush_miss", last_rsp - last_g, 18);
    req(2, 9'd0); run(2);
    check("lat_zero", last_rsp - last_g, 1);
    req(2, 9'd3); run(2);
    check("lat_hit_after_zero", last_rsp - last_g, 1);
    req(3, 9'd3); run(2);
    gq.delete();
    rerq = 4'b0001;
    req(0, 9'd10); req(1, 9'd20); req(2, 9'd30); req(3, 9'd40);
    run(100);
    check("rr_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("rr_order", gq[i], exp_ord[i]);
    req(0, 9'd100); run(8);
    rst_n = 1'b0; req_valid = '0; model_clear();
    run(2);
    check("mid_rst_recip", rsp_recip, 16'h0);
    check("mid_rst_denom", div_denom, 9'h0);
    rst_n = 1'b1;
    run(25);
    req(1, 9'd3); run(20);
    check("lat_after_rst", last_rsp - last_g, 18);
    req(1, 9'd77); run(1);
    flush_at = cyc + 16;
    run(18);
    req(1, 9'd77); run(2);
    check("lat_fill_over_flush", last_rsp - last_g, 1);
    rnd = 1'b1;
    run(3000);
    rnd = 1'b0;
    req_valid = '0;
    run(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/recip_sched.md
# recip_sched

Shares one iterative 9-bit-denominator reciprocal divider between up to `N_REQ` requesters, such as per-scanline perspective and shading units in the VGA demo pipeline. Arbitration is round-robin. The block sequences the divider's `start` pulse and waits its fixed iteration latency. It then returns the 16-bit reciprocal to the granted requester. Two shortcuts skip the divider: a one-entry last-result cache, and a divide-by-zero path that saturates.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DIV_LATENCY`, 16: cycles from the divider `start` cycle to a stable `div_recip`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request; held with `req_denom` slice stable until `req_ready`.
- `req_denom`  in  9*N_REQ  denominator, slice i = `[9*i+8:9*i]`.
- `req_ready`  out  N_REQ  one-hot, one-cycle grant pulse; denominator is latched this cycle.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle result pulse to the granted requester.
- `rsp_recip`  out  16  result; valid only while some `rsp_valid` bit is high, held otherwise.
- `flush`  in  1  invalidates the cache.
- `div_start`  out  1  one-cycle start to the divider.
- `div_denom`  out  9  denominator to the divider; stable from `div_start` until the result is sampled.
- `div_recip`  in  16  divider result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- **IDLE.** If any `req_valid` bit is high:
  - Grant the first valid index at or after `rr_ptr`, wrapping modulo N_REQ.
  - Pulse `req_ready[g]`, latch the denominator into `cur_denom` and `cur_id`.
  - Set `rr_ptr <= (g+1) mod N_REQ`.
- **Fast paths, decided in the grant cycle.**
  - Denominator 0: next cycle `rsp_valid[g]`=1 and `rsp_recip`=16'hFFFF. The divider is not started, the cache is unchanged, and the FSM stays in IDLE.
  - Cache hit (`cache_v` && denominator == `cache_denom`): next cycle `rsp_valid[g]`=1 and `rsp_recip`=`cache_recip`. The FSM stays in IDLE.
  - Otherwise go to ISSUE.
- **ISSUE.** `div_start`=1, `div_denom`=`cur_denom`, counter loaded with DIV_LATENCY-1. Go to WAIT.
- **WAIT.** Decrement the counter; when it reaches 0, go to CAPTURE.
- **CAPTURE.** Sample `div_recip` into `rsp_recip`, `cache_recip` and `cache_denom`, set `cache_v`=1, and pulse `rsp_valid[cur_id]` on the next cycle. Go to IDLE.
- **Grant rules.**
  - Grants are issued only in IDLE; requests arriving in other states wait.
  - A requester may reassert `req_valid` right after its grant. The new request is serviced in order behind any pending requests, per round-robin.
- **Flush.**
  - `flush` clears `cache_v` on the next edge.
  - `flush` asserted in the same cycle as a cache lookup in IDLE forces a miss.
  - `flush` asserted in CAPTURE: the fill wins and `cache_v`=1.
- **Reset values.** All outputs and `rr_ptr` are 0; `cache_v`=0; state is IDLE.
- **Reset mid-operation.** The result of an in-flight divider run is discarded and no `rsp_valid` is emitted. The next ISSUE restarts the divider, so stale divider state is harmless.
- **Width rules.** `rsp_recip` is `div_recip` passed through unmodified; the block does no arithmetic on the result.

## Timing
- Grant cycle g: `req_ready` is high during g.
- Fast path (zero or cache hit): `rsp_valid` at g+1. IDLE can grant another request in g+1, giving 1 request/cycle throughput.
- Divider path:
  - ISSUE (`div_start`) at g+1.
  - `div_recip` sampled at g+1+DIV_LATENCY, which is g+17 by default.
  - `rsp_valid` at g+2+DIV_LATENCY, which is g+18.
  - IDLE at g+18 can grant in that same cycle, so back-to-back misses give one result per DIV_LATENCY+2 cycles.
- `div_denom` holds `cur_denom` from ISSUE through CAPTURE. `div_start` is never high outside ISSUE.
- `rsp_valid` bits are mutually exclusive, and at most one `req_ready` bit is high per cycle.

## Test plan
- Single miss: r0 requests 256 after reset, with the bench divider model returning floor(65536/d) after 16 cycles. Expect `req_ready[0]` at g, `div_start` at g+1, `rsp_valid[0]` with 0x0100 at g+18.
- Cache hit then flush: r1 requests 3 (miss, 0x5555), then 3 again. Expect `rsp_valid[1]` with 0x5555 one cycle after the grant and no `div_start`. Pulse `flush`, request 3 again, and expect `div_start` and a g+18 response.
- Zero denominator: r2 requests 0. Expect `rsp_valid[2]` with 0xFFFF at g+1, no `div_start`, and the cache unchanged (a following hit on the prior value still works).
- Round-robin: all four requesters hold `req_valid` with distinct misses. Expect grants in order 0,1,2,3,0 with each response routed to the matching `rsp_valid` bit. A requester re-requesting immediately waits its turn.
- Reset mid-WAIT: assert `rst_n`=0 at g+8. Expect all outputs 0, no `rsp_valid`, and `cache_v`=0. A new request after reset is serviced normally.
- Flush in CAPTURE: assert `flush` in CAPTURE. Expect the entry cached and an immediate repeat request to hit.
